// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating counters,
// Execute-stage resolution with PC mux select, and wrap-around performance counters.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic [31:0] PCTargetE,
  input  logic [1:0]  BranchOpE,
  input  logic        PCTakenE,
  input  logic        PCSrcPredE,
  input  logic        TargetMatchE,
  input  logic        StallE,
  output logic [31:0] PredPCTargetF,
  output logic        PCSrcPredF,
  output logic [1:0]  PCSrc,
  output logic        MispredictE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned IDX_LO  = 2;
  localparam int unsigned TAG_LO  = INDEX_BITS + 2;
  localparam int unsigned TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  localparam logic [1:0] OP_JUMP   = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  localparam logic [1:0] SRC_PLUS4F = 2'b00;
  localparam logic [1:0] SRC_PRED   = 2'b01;
  localparam logic [1:0] SRC_TGTE   = 2'b10;
  localparam logic [1:0] SRC_PLUS4E = 2'b11;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;

  logic is_jump, is_branch, resolve, taken_e, alias_e, mis_resolve, mispredict_c;

  logic                  wr_meta, wr_tgt, wr_valid;
  logic [1:0]            wr_ctr;

  assign idx_f = PCF[INDEX_BITS+1:IDX_LO];
  assign tag_f = PCF[TAG_HI:TAG_LO];
  assign idx_e = PCE[INDEX_BITS+1:IDX_LO];
  assign tag_e = PCE[TAG_HI:TAG_LO];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  // Fetch lookup
  assign PCSrcPredF    = hit_f && ctr_q[idx_f][1];
  assign PredPCTargetF = target_q[idx_f];

  // Execute resolution; opcode 11 behaves as non-control
  assign is_jump     = (BranchOpE == OP_JUMP);
  assign is_branch   = (BranchOpE == OP_BRANCH);
  assign resolve     = !StallE && (is_jump || is_branch);
  assign taken_e     = is_jump || (is_branch && PCTakenE);
  assign alias_e     = !StallE && !is_jump && !is_branch && PCSrcPredE;
  assign mis_resolve = resolve &&
                       ((taken_e != PCSrcPredE) || (taken_e && PCSrcPredE && !TargetMatchE));
  assign mispredict_c = reset && (mis_resolve || alias_e);
  assign MispredictE  = mispredict_c;

  always_comb begin
    PCSrc = SRC_PLUS4F;
    if (!reset)                     PCSrc = SRC_PLUS4F;
    else if (mispredict_c &&  taken_e) PCSrc = SRC_TGTE;
    else if (mispredict_c)          PCSrc = SRC_PLUS4E;
    else if (PCSrcPredF)            PCSrc = SRC_PRED;
  end

  // BTB write decode for the Execute instruction
  always_comb begin
    wr_meta  = 1'b0;
    wr_tgt   = 1'b0;
    wr_valid = 1'b1;
    wr_ctr   = ctr_q[idx_e];
    if (!StallE) begin
      if (is_jump) begin
        wr_meta = 1'b1;
        wr_tgt  = 1'b1;
        wr_ctr  = 2'b11;
      end else if (is_branch) begin
        if (hit_e) begin
          wr_meta = 1'b1;
          wr_tgt  = PCTakenE;
          if (PCTakenE && ctr_q[idx_e] != 2'b11)
            wr_ctr = ctr_q[idx_e] + 2'd1;
          else if (!PCTakenE && ctr_q[idx_e] != 2'b00)
            wr_ctr = ctr_q[idx_e] - 2'd1;
        end else if (PCTakenE) begin
          wr_meta = 1'b1;
          wr_tgt  = 1'b1;
          wr_ctr  = 2'b10;
        end
      end else if (PCSrcPredE) begin
        wr_meta  = 1'b1;
        wr_valid = 1'b0;
      end
    end
  end

  assign branch_cnt_d = branch_cnt_q + 32'(resolve);
  assign mis_cnt_d    = mis_cnt_q + 32'(mispredict_c);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
      if (wr_meta) begin
        valid_q[idx_e] <= wr_valid;
        tag_q[idx_e]   <= tag_e;
        ctr_q[idx_e]   <= wr_ctr;
      end
      if (wr_tgt) target_q[idx_e] <= PCTargetE;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mis_cnt_q;

  // High and byte-offset PC bits do not take part in indexing or tagging
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[31:TAG_HI+1], PCF[1:0], PCE[31:TAG_HI+1], PCE[1:0]};

endmodule
